// File: rtl/eq_seq_pkg.sv
// Shared types, default geometry and elaboration checks for the sequential equality unit.
package eq_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SLICE = 2;
  localparam int unsigned NSL       = DEF_WIDTH / DEF_SLICE;
  localparam int unsigned IW        = $clog2(NSL);

  // Operand width must split evenly into slices.
  function automatic bit width_ok(input int unsigned w, input int unsigned s);
    return (s != 0) && ((w % s) == 0);
  endfunction

endpackage

// File: rtl/eq_slice.sv
// SLICE-wide equality cell: per-bit XNOR reduced by AND into one match flag.
module eq_slice #(
  parameter int unsigned SLICE = 2
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  output logic             match_c
);

  logic [SLICE-1:0] xnor_c;

  assign xnor_c  = ~(a_i ^ b_i);
  assign match_c = &xnor_c;

endmodule

// File: rtl/eq_compare_sequencer.sv
// Multi-cycle equality compare, one SLICE per cycle, LSB slice first.
// Optional macro EQ_SEQ_EARLY_EXIT_EN: finish on the first mismatching slice.
module eq_compare_sequencer
  import eq_seq_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SLICE = DEF_SLICE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [WIDTH-1:0]                a,
  input  logic [WIDTH-1:0]                b,
  output logic                            res_valid,
  input  logic                            res_ready,
  output logic                            eq,
  output logic [$clog2(WIDTH/SLICE)-1:0]  miss_idx,
  output logic                            busy
);

  localparam int unsigned N   = WIDTH / SLICE;
  localparam int unsigned IWL = $clog2(N);

  if (!width_ok(WIDTH, SLICE)) begin : g_bad_width
    $error("eq_compare_sequencer: WIDTH must be a multiple of SLICE");
  end

  state_e           state_q;
  logic [IWL-1:0]   idx_q;
  logic [IWL-1:0]   miss_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic             eq_acc_q;

  logic             match_c;
  logic             last_c;
  logic             exit_c;
  logic             first_miss_c;

  eq_slice #(.SLICE(SLICE)) u_slice (
    .a_i     (a_q[idx_q*SLICE +: SLICE]),
    .b_i     (b_q[idx_q*SLICE +: SLICE]),
    .match_c (match_c)
  );

  assign last_c       = (idx_q == IWL'(N - 1));
  assign first_miss_c = eq_acc_q && !match_c;

`ifdef EQ_SEQ_EARLY_EXIT_EN
  assign exit_c = last_c || !match_c;
`else
  assign exit_c = last_c;
`endif

  // FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      miss_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      eq_acc_q  <= 1'b0;
      req_ready <= 1'b1;
      res_valid <= 1'b0;
      eq        <= 1'b0;
      miss_idx  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            a_q       <= a;
            b_q       <= b;
            eq_acc_q  <= 1'b1;
            idx_q     <= '0;
            miss_q    <= '0;
            state_q   <= RUN;
            req_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end
        RUN: begin
          eq_acc_q <= eq_acc_q & match_c;
          if (first_miss_c) miss_q <= idx_q;
          if (exit_c) begin
            // Publish the final verdict together with res_valid.
            eq        <= eq_acc_q & match_c;
            miss_idx  <= first_miss_c ? idx_q : miss_q;
            state_q   <= DONE;
            res_valid <= 1'b1;
            busy      <= 1'b0;
          end else begin
            idx_q <= idx_q + IWL'(1);
          end
        end
        DONE: begin
          if (res_ready) begin
            state_q   <= IDLE;
            res_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          req_ready <= 1'b1;
          res_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
